frame_stream_sched: RTL
=======================

Name: frame_stream_sched

Overview:
- Frame sequencer between the byte-stream image source (8-bit AXIS, raw RGB file with fixed-length header) and the downstream tracker datapath.
- Discards the per-frame header bytes and counts payload bytes into channel/x/y.
- Tags the stream with start-of-frame (tuser) and end-of-line (tlast), and schedules a programmed number of frames with start/abort control.
- Decouples input and output handshakes through a 2-entry skid buffer, so s_axis_tready never depends combinationally on m_axis_tready.

Parameters:
- HEADER_BYTES, 15, bytes discarded at the start of every frame (0 = no header).
- WIDTH, 224, pixels per line.
- HEIGHT, 224, lines per frame.
- CHANNELS, 3, bytes per pixel.
- CNT_W, 18, width of the payload byte counter; must hold WIDTH*HEIGHT*CHANNELS-1.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE; latches num_frames.
- abort  in  1  one-cycle pulse; graceful stop, see Behaviour.
- num_frames  in  16  frames to run; 0 = run continuously until abort.
- busy  out  1  high from the start accept until return to IDLE.
- frame_done  out  1  one-cycle pulse when the last byte of a frame leaves m_axis.
- frame_cnt  out  16  frames completed since start; wraps modulo 2^16.
- byte_cnt  out  CNT_W  payload bytes accepted in the current frame.
- s_axis_tdata  in  8  source byte.
- s_axis_tvalid  in  1  source valid.
- s_axis_tready  out  1  source ready (registered).
- m_axis_tdata  out  8  payload byte.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tuser  out  1  high on the first payload byte of a frame.
- m_axis_tlast  out  1  high on the last byte of each line (x==WIDTH-1, ch==CHANNELS-1).

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; skid buffer empty.
- A transfer occurs on any cycle where valid&&ready are both high. The block counts only transfers.
- State IDLE:
  - s_axis_tready=0.
  - start latches num_frames, sets busy=1 and clears frame_cnt.
  - Next state is HEADER, or STREAM when HEADER_BYTES==0.
- State HEADER:
  - s_axis_tready=1; accepted bytes are dropped and never reach the buffer.
  - After exactly HEADER_BYTES transfers, go to STREAM.
- State STREAM:
  - s_axis_tready = skid buffer not full.
  - Each accepted byte is pushed with its tuser/tlast tags; ch, x, y and byte_cnt advance.
  - ch wraps at CHANNELS-1 and increments x; x wraps at WIDTH-1 and increments y.
  - When the frame's final byte (byte_cnt == WIDTH*HEIGHT*CHANNELS-1) is accepted: s_axis_tready drops the next cycle, counters clear, go to DRAIN.
- State DRAIN:
  - s_axis_tready=0.
  - When the last tagged byte transfers on m_axis: pulse frame_done and increment frame_cnt in the same cycle.
  - If num_frames==0 or frame_cnt+1 < num_frames, go to HEADER; otherwise go to IDLE with busy=0.
- Latency: 1 cycle from s_axis transfer to m_axis_tvalid when the buffer is empty. Full throughput of 1 byte/cycle when m_axis_tready is held high.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tuser/tlast stay stable.
- Abort:
  - s_axis_tready=0 from the next cycle. Bytes already buffered drain normally.
  - Then go to IDLE, busy=0, counters cleared. No frame_done unless the drained byte ends a frame.
  - Abort in IDLE is ignored. Abort in the same cycle as start: abort wins and start is ignored.
  - start while busy is ignored.
- rst mid-frame: immediate return to reset values; buffer contents discarded.

Optional Feature:
- FRAME_CHECKSUM_EN defined:
  - adds output frame_sum[15:0], a modulo-2^16 sum of all payload bytes of the frame, computed on the m_axis side;
  - frame_sum is valid in the frame_done cycle and holds until the next frame_done or rst;
  - header bytes are excluded.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package frame_stream_pkg: state encoding (IDLE, HEADER, STREAM, DRAIN), FRAME_BYTES = WIDTH*HEIGHT*CHANNELS, and the counter-width helper.
- Sub-module axis_skid_buf: 2-entry, 10-bit payload (data, tuser, tlast); outputs full/empty; registered ready.

Test Plan (WIDTH=4, HEIGHT=2, CHANNELS=3, HEADER_BYTES=15 unless noted):
1. Header skip: start with num_frames=1 and source bytes 0..38 -> m_axis carries bytes 15..38 (24 bytes); tuser only on byte 15; tlast on bytes 26 and 38; single frame_done; frame_cnt=1; busy low after.
2. Back-pressure: m_axis_tready toggling 1-0-0-1 and source tvalid random, num_frames=2 -> 48 payload bytes, none lost or duplicated; data stable while stalled; frame_cnt=2.
3. HEADER_BYTES=0, continuous (num_frames=0) for 3 frames, then abort mid-frame 4 -> frame_done ×3; buffered bytes drained; IDLE; busy=0.
4. Abort and start in the same cycle while in IDLE -> start ignored; busy stays 0.
5. rst asserted at byte 10 of the payload -> all outputs 0 next cycle; a new start restarts cleanly with tuser on the first payload byte.
6. FRAME_CHECKSUM_EN with payload all 0xFF -> frame_sum = 24*255 = 0x17E8 at frame_done.

Source files
------------

// File: rtl/frame_stream_pkg.sv
// Shared definitions for the frame sequencer: FSM state encoding, frame size
// and counter-width helpers, skid buffer payload width.
package frame_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Payload carried through the skid buffer: {data[7:0], tuser, tlast}
  localparam int SKID_W = 10;

  function automatic int frame_bytes(input int w, input int h, input int c);
    return w * h * c;
  endfunction

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while (w < 31 && (1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer. Input ready is a flop computed from the next
// occupancy, so the upstream side never sees the downstream ready combinationally.
module axis_skid_buf
  import frame_stream_pkg::*;
#(
  parameter int DATA_W = SKID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              push;
  logic              pop;

  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign count_nxt = count + {1'b0, push} - {1'b0, pop};
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);
  assign m_valid   = !empty;
  assign m_data    = mem[rd_ptr];

  // Occupancy, pointers and registered input ready
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      s_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count   <= count_nxt;
      s_ready <= (count_nxt != 2'd2);
    end
  end

  // Storage; contents are only observed while the matching entry is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule

// File: rtl/frame_stream_sched.sv
// Frame sequencer: strips the per-frame header, tags payload bytes with
// start-of-frame / end-of-line and schedules a programmed number of frames.
// Optional feature macro: FRAME_CHECKSUM_EN adds frame_sum, a modulo-2^16
// sum of each frame's payload bytes taken on the output side.
module frame_stream_sched
  import frame_stream_pkg::*;
#(
  parameter int HEADER_BYTES = 15,
  parameter int WIDTH        = 224,
  parameter int HEIGHT       = 224,
  parameter int CHANNELS     = 3,
  parameter int CNT_W        = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      num_frames,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] byte_cnt,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
`ifdef FRAME_CHECKSUM_EN
  output logic [15:0]      frame_sum,
`endif
  output logic             m_axis_tlast
);

  localparam int HDR_W = cnt_width(HEADER_BYTES);
  localparam int X_W   = cnt_width(WIDTH - 1);
  localparam int Y_W   = cnt_width(HEIGHT - 1);
  localparam int C_W   = cnt_width(CHANNELS - 1);
  localparam state_t FIRST_ST = (HEADER_BYTES == 0) ? ST_STREAM : ST_HEADER;

  state_t           state;
  logic             aborting;
  logic             end_pend;
  logic [15:0]      num_q;
  logic [HDR_W-1:0] hdr_cnt;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [C_W-1:0]   ch;

  logic              buf_rdy, buf_vld, buf_full, buf_empty;
  logic [SKID_W-1:0] buf_out;
  logic              s_xfer, hdr_xfer, pay_xfer, m_xfer;
  logic              ch_wrap, x_wrap, last_byte, tuser_in, tlast_in;
  logic              drain_last, drain_fin, more_frames;

  assign s_axis_tready = (state == ST_HEADER) || ((state == ST_STREAM) && buf_rdy);
  assign s_xfer        = s_axis_tvalid && s_axis_tready;
  assign hdr_xfer      = s_xfer && (state == ST_HEADER);
  assign pay_xfer      = s_xfer && (state == ST_STREAM);
  assign m_xfer        = buf_vld && m_axis_tready;

  assign ch_wrap   = (ch == C_W'(CHANNELS - 1));
  assign x_wrap    = (x == X_W'(WIDTH - 1));
  assign last_byte = ch_wrap && x_wrap && (y == Y_W'(HEIGHT - 1));
  assign tuser_in  = (byte_cnt == '0);
  assign tlast_in  = ch_wrap && x_wrap;

  // In DRAIN nothing is pushed, so a pop from a non-full buffer empties it
  assign drain_last  = (state == ST_DRAIN) && m_xfer && !buf_full;
  assign drain_fin   = drain_last || ((state == ST_DRAIN) && buf_empty);
  assign frame_done  = drain_last && end_pend;
  assign more_frames = (num_q == 16'd0) || (({1'b0, frame_cnt} + 17'd1) < {1'b0, num_q});

  assign m_axis_tvalid = buf_vld;
  assign m_axis_tdata  = buf_vld ? buf_out[9:2] : 8'd0;
  assign m_axis_tuser  = buf_vld && buf_out[1];
  assign m_axis_tlast  = buf_vld && buf_out[0];

  axis_skid_buf #(.DATA_W(SKID_W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({s_axis_tdata, tuser_in, tlast_in}),
    .s_valid (s_axis_tvalid && (state == ST_STREAM)),
    .s_ready (buf_rdy),
    .m_data  (buf_out),
    .m_valid (buf_vld),
    .m_ready (m_axis_tready),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  // Frame scheduler FSM with header/payload position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      aborting  <= 1'b0;
      end_pend  <= 1'b0;
      num_q     <= 16'd0;
      frame_cnt <= 16'd0;
      byte_cnt  <= '0;
      hdr_cnt   <= '0;
      x         <= '0;
      y         <= '0;
      ch        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            num_q     <= num_frames;
            busy      <= 1'b1;
            frame_cnt <= 16'd0;
            state     <= FIRST_ST;
          end
        end
        ST_HEADER: begin
          if (abort) begin
            aborting <= 1'b1;
            hdr_cnt  <= '0;
            state    <= ST_DRAIN;
          end else if (hdr_xfer) begin
            if (hdr_cnt == HDR_W'(HEADER_BYTES - 1)) begin
              hdr_cnt <= '0;
              state   <= ST_STREAM;
            end else begin
              hdr_cnt <= hdr_cnt + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (pay_xfer) begin
            if (last_byte) begin
              byte_cnt <= '0;
              ch       <= '0;
              x        <= '0;
              y        <= '0;
              end_pend <= 1'b1;
              state    <= ST_DRAIN;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              ch       <= ch_wrap ? '0 : ch + 1'b1;
              if (ch_wrap) begin
                x <= x_wrap ? '0 : x + 1'b1;
                if (x_wrap) y <= y + 1'b1;
              end
            end
          end
          if (abort) begin
            aborting <= 1'b1;
            byte_cnt <= '0;
            ch       <= '0;
            x        <= '0;
            y        <= '0;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort) aborting <= 1'b1;
          if (drain_fin) begin
            end_pend <= 1'b0;
            aborting <= 1'b0;
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
            if (aborting || abort || !more_frames) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= FIRST_ST;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [15:0] sum_acc;
  logic [15:0] sum_q;
  logic [15:0] sum_in;

  // Running sum restarts on the start-of-frame byte
  assign sum_in    = (m_axis_tuser ? 16'd0 : sum_acc) + {8'd0, m_axis_tdata};
  assign frame_sum = frame_done ? sum_in : sum_q;

  // Output-side payload accumulation and per-frame hold
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc <= 16'd0;
      sum_q   <= 16'd0;
    end else begin
      if (m_xfer)     sum_acc <= sum_in;
      if (frame_done) sum_q   <= sum_in;
    end
  end
`endif

endmodule
